// File: rtl/synch_bank.sv
// synch_bank: WIDTH independent pin synchronisers, each with an optional glitch filter and rise/fall strobes.
// Define SYNCH_BANK_FILTER_EN to include the FILT_LEN-cycle filter; otherwise Y is the last sync stage directly.
module synch_bank #(
   parameter int unsigned      WIDTH    = 3,
   parameter int unsigned      STAGES   = 2,
   parameter int unsigned      FILT_LEN = 4,
   parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] Y,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

   if (STAGES < 2) begin : gBadStages
      $fatal(1, "synch_bank: STAGES must be >= 2");
   end
   if (FILT_LEN < 1) begin : gBadFiltLen
      $fatal(1, "synch_bank: FILT_LEN must be >= 1");
   end

   // Synchroniser chain: index 0 samples the pin, index STAGES-1 is the settled value.
   logic [STAGES-1:0][WIDTH-1:0] syncQ;
   logic [WIDTH-1:0]             s;

   // NOTE: registers use non-blocking assignments so every flop samples the pre-edge value of its neighbour.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         syncQ <= {STAGES{RST_VAL}};
      end else begin
         syncQ <= {syncQ[STAGES-2:0], A};
      end
   end

   assign s = syncQ[STAGES-1];

`ifdef SYNCH_BANK_FILTER_EN
   localparam int unsigned      CNT_W   = $clog2(FILT_LEN + 1);
   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(FILT_LEN - 1);

   logic [CNT_W-1:0] filtCnt [WIDTH];

   // Y follows s only after s has disagreed with it on FILT_LEN consecutive edges.
   // NOTE: the counter array is reset explicitly; a partial count must not survive a reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         Y <= RST_VAL;
         for (int i = 0; i < int'(WIDTH); i++) begin
            filtCnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(WIDTH); i++) begin
            if (s[i] == Y[i]) begin
               filtCnt[i] <= '0;
            end else if (filtCnt[i] == CNT_TOP) begin
               Y[i]       <= s[i];
               filtCnt[i] <= '0;
            end else begin
               filtCnt[i] <= filtCnt[i] + CNT_W'(1);
            end
         end
      end
   end
`else
   assign Y = s;
`endif

   // Edge history; strobes come only from registers so they cannot glitch.
   logic [WIDTH-1:0] Yd;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         Yd <= RST_VAL;
      end else begin
         Yd <= Y;
      end
   end

   assign rise = Y & ~Yd;
   assign fall = ~Y & Yd;

endmodule

// File: tb/tb_synch_bank.sv
// tb_synch_bank: table-driven and randomized checks of synch_bank against a queue-based reference model.
module tb_synch_bank;

`ifdef SYNCH_BANK_FILTER_EN
   localparam bit FILT_ON = 1'b1;
   localparam int STAGES  = 2;
`else
   localparam bit FILT_ON = 1'b0;
   localparam int STAGES  = 3;
`endif
   localparam int         FILT_LEN = 4;
   localparam int         LAT      = FILT_ON ? STAGES + FILT_LEN : STAGES;
   localparam logic [2:0] RST_VAL  = 3'b010;

   typedef struct {
      logic [2:0] a;
      logic [2:0] expY;
      logic [2:0] expRise;
      logic [2:0] expFall;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] A   = RST_VAL;
   logic [2:0] Y, rise, fall;

   int nErr    = 0;
   int nChecks = 0;
   bit modelOn = 1'b0;

   synch_bank #(
      .WIDTH(3), .STAGES(STAGES), .FILT_LEN(FILT_LEN), .RST_VAL(RST_VAL)
   ) dut (
      .clk(clk), .rst(rst), .A(A), .Y(Y), .rise(rise), .fall(fall)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: A delayed through a queue of STAGES samples, then a run-length rule on each bit.
   logic [2:0] mPipe[$];
   logic [2:0] mY, mYd, sOld;
   int         mRun[3];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mPipe.delete();
         for (int i = 0; i < STAGES; i++) mPipe.push_back(RST_VAL);
         mY   = RST_VAL;
         mYd  = RST_VAL;
         mRun = '{default: 0};
      end else begin
         sOld = mPipe[0];
         mYd  = mY;
         mPipe.push_back(A);
         void'(mPipe.pop_front());
         if (FILT_ON) begin
            for (int i = 0; i < 3; i++) begin
               mRun[i] = (sOld[i] != mY[i]) ? mRun[i] + 1 : 0;
               if (mRun[i] == FILT_LEN) begin
                  mY[i]   = sOld[i];
                  mRun[i] = 0;
               end
            end
         end else begin
            mY = mPipe[0];
         end
      end
   end

   always @(negedge clk) begin
      if (modelOn) begin
         check("model_Y", Y, mY);
         check("model_rise", rise, mY & ~mYd);
         check("model_fall", fall, ~mY & mYd);
         check("rise_fall_excl", rise & fall, 3'b000);
      end
   end

   vec_t       vecs[8];
   logic [2:0] prevY;
   int         hi, nr, nf, expHi, preRst;
   int         pulses[3] = '{1, 3, 4};

   initial begin
      vecs[0] = '{3'b010, 3'b010, 3'b000, 3'b000};
      vecs[1] = '{3'b111, 3'b111, 3'b101, 3'b000};
      vecs[2] = '{3'b000, 3'b000, 3'b000, 3'b111};
      vecs[3] = '{3'b101, 3'b101, 3'b101, 3'b000};
      vecs[4] = '{3'b010, 3'b010, 3'b010, 3'b101};
      vecs[5] = '{3'b110, 3'b110, 3'b100, 3'b000};
      vecs[6] = '{3'b011, 3'b011, 3'b001, 3'b100};
      vecs[7] = '{3'b010, 3'b010, 3'b000, 3'b001};

      // Held in reset with A toggling: outputs pinned to RST_VAL, no strobes.
      #1 rst = 1'b1;
      modelOn = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         check("rst_Y", Y, RST_VAL);
         check("rst_rise", rise, 3'b000);
         check("rst_fall", fall, 3'b000);
         A = 3'($urandom);
      end
      rst = 1'b0;
      A   = RST_VAL;
      @(negedge clk);
      check("rel_Y", Y, RST_VAL);
      check("rel_rise", rise, 3'b000);
      check("rel_fall", fall, 3'b000);
      repeat (LAT + 2) @(negedge clk);

      // Table: each new A value must appear on Y on exactly the LAT-th edge with one-cycle strobes.
      prevY = RST_VAL;
      for (int v = 0; v < 8; v++) begin
         A = vecs[v].a;
         repeat (LAT - 1) @(posedge clk);
         @(negedge clk);
         check("tbl_hold_Y", Y, prevY);
         @(negedge clk);
         check("tbl_Y", Y, vecs[v].expY);
         check("tbl_rise", rise, vecs[v].expRise);
         check("tbl_fall", fall, vecs[v].expFall);
         @(negedge clk);
         check("tbl_rise_end", rise, 3'b000);
         check("tbl_fall_end", fall, 3'b000);
         prevY = vecs[v].expY;
         repeat (2) @(negedge clk);
      end

      // Pulses on A[0]: short ones are swallowed by the filter, long ones pass with their width intact.
      A = 3'b000;
      repeat (LAT + 3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         hi = 0; nr = 0; nf = 0;
         for (int c = 0; c < LAT + 12; c++) begin
            if (c == 0) A = 3'b001;
            if (c == pulses[k]) A = 3'b000;
            @(negedge clk);
            hi += int'(Y[0]);
            nr += int'(rise[0]);
            nf += int'(fall[0]);
         end
         expHi = (!FILT_ON || pulses[k] >= FILT_LEN) ? pulses[k] : 0;
         check("pulse_high_cycles", hi, expHi);
         check("pulse_rise_count", nr, (expHi > 0) ? 1 : 0);
         check("pulse_fall_count", nf, (expHi > 0) ? 1 : 0);
      end

      // Asynchronous reset in the middle of a filter count; the count restarts from zero afterwards.
      preRst = FILT_ON ? STAGES + 2 : 1;
      A = 3'b001;
      repeat (preRst) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_Y", Y, RST_VAL);
      check("arst_rise", rise, 3'b000);
      check("arst_fall", fall, 3'b000);
      @(negedge clk);
      rst = 1'b0;
      repeat (LAT - 1) @(posedge clk);
      @(negedge clk);
      check("arst_hold_Y", Y, RST_VAL);
      @(negedge clk);
      check("arst_new_Y", Y, 3'b001);
      check("arst_new_rise", rise, 3'b001);
      check("arst_new_fall", fall, 3'b010);

      // Random bursts of varying hold time, checked cycle by cycle against the model.
      for (int b = 0; b < 40; b++) begin
         A = 3'($urandom);
         repeat ($urandom_range(1, 6)) @(negedge clk);
         if (b == 20) begin
            #2 rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
      end
      repeat (LAT + 3) @(negedge clk);

      modelOn = 1'b0;
      $display("Result: errors=%0d of %0d checks", nErr, nChecks);
      $finish;
   end

endmodule
